// File: rtl/ff_override_monitor.sv
// ff_override_monitor
// ---------------------------------------------------------------------------
// Passive checker placed beside a D flip-flop that can be overridden by a
// procedural force or preset. It keeps a shadow copy of the flop, driven by the
// same clock, reset and D, and compares the shadow against the observed Q on
// every rising edge. A mismatch opens an override episode. The block reports
// when an episode starts and ends, the forced value, how many episodes have
// closed and how long the last one lasted.
//
// Parameters:
//   CNT_W    width of the episode counter and the length counters
//   REL_CYC  consecutive matching samples needed to close an episode (1..15)
//
// Ports:
//   clk          in   clock shared with the monitored flop
//   rst          in   synchronous active-high reset shared with the flop
//   d            in   D presented to the monitored flop
//   q            in   observed Q of the monitored flop
//   en           in   compare enable; while low every sample is a match
//   ovr_active   out  high while an episode is open
//   ovr_start    out  one-cycle pulse when an episode opens
//   ovr_end      out  one-cycle pulse when an episode closes
//   ovr_val      out  q captured at the opening sample of the latest episode
//   ovr_count    out  number of closed episodes, saturating
//   ovr_len      out  mismatching samples in the last closed episode, saturating
//   ovr_len_max  out  largest ovr_len since reset (only with OVR_LEN_MAX_EN)
//
// Build option:
//   OVR_LEN_MAX_EN  when defined, adds the ovr_len_max port and its register.
// ---------------------------------------------------------------------------
module ff_override_monitor #(
  parameter int CNT_W   = 8,
  parameter int REL_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             q,
  input  logic             en,
  output logic             ovr_active,
  output logic             ovr_start,
  output logic             ovr_end,
  output logic             ovr_val,
  output logic [CNT_W-1:0] ovr_count,
`ifdef OVR_LEN_MAX_EN
  output logic [CNT_W-1:0] ovr_len_max,
`endif
  output logic [CNT_W-1:0] ovr_len
);

  typedef enum logic [1:0] {
    MATCH    = 2'd0,
    OVERRIDE = 2'd1,
    RECOVER  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] SAT     = '1;
  localparam logic [3:0]       REL_LIM = 4'(REL_CYC);

  state_t           state;
  state_t           state_next;
  logic             q_exp;
  logic             mis;
  logic [CNT_W-1:0] run_len;
  logic [3:0]       rel_cnt;

  logic open_ep;
  logic close_ep;
  logic extend_ep;
  logic enter_rec;
  logic step_rec;

  // Comparison uses the pre-edge q and shadow value and is masked while the
  // shared reset is asserted, so the flop's own reset never looks like an override.
  assign mis = en & ~rst & (q != q_exp);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MATCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the single-cycle actions that the datapath applies
  // on the same edge. Matching samples in RECOVER only advance the release
  // counter; they never add to the episode length.
  always_comb begin
    state_next = state;
    open_ep    = 1'b0;
    close_ep   = 1'b0;
    extend_ep  = 1'b0;
    enter_rec  = 1'b0;
    step_rec   = 1'b0;
    case (state)
      MATCH: begin
        if (mis) begin
          state_next = OVERRIDE;
          open_ep    = 1'b1;
        end
      end
      OVERRIDE: begin
        if (mis) begin
          extend_ep = 1'b1;
        end else if (REL_CYC == 1) begin
          state_next = MATCH;
          close_ep   = 1'b1;
        end else begin
          state_next = RECOVER;
          enter_rec  = 1'b1;
        end
      end
      RECOVER: begin
        if (mis) begin
          state_next = OVERRIDE;
          extend_ep  = 1'b1;
        end else if (rel_cnt + 4'd1 == REL_LIM) begin
          state_next = MATCH;
          close_ep   = 1'b1;
        end else begin
          step_rec = 1'b1;
        end
      end
      default: begin
        state_next = MATCH;
      end
    endcase
  end

  // Output decode: an episode is open whenever the FSM is away from MATCH.
  // The state is registered, so this output is registered as well.
  always_comb begin
    ovr_active = (state != MATCH);
  end

  // Shadow flop, episode counters and the registered report outputs.
  // A reset discards any open episode without counting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_exp     <= 1'b0;
      run_len   <= '0;
      rel_cnt   <= '0;
      ovr_start <= 1'b0;
      ovr_end   <= 1'b0;
      ovr_val   <= 1'b0;
      ovr_count <= '0;
      ovr_len   <= '0;
    end else begin
      q_exp     <= d;
      ovr_start <= open_ep;
      ovr_end   <= close_ep;
      if (open_ep) begin
        ovr_val <= q;
        run_len <= CNT_W'(1);
      end
      if (extend_ep) begin
        rel_cnt <= '0;
        if (run_len != SAT) begin
          run_len <= run_len + CNT_W'(1);
        end
      end
      if (enter_rec) begin
        rel_cnt <= 4'd1;
      end
      if (step_rec) begin
        rel_cnt <= rel_cnt + 4'd1;
      end
      if (close_ep) begin
        rel_cnt <= '0;
        ovr_len <= run_len;
        if (ovr_count != SAT) begin
          ovr_count <= ovr_count + CNT_W'(1);
        end
      end
    end
  end

`ifdef OVR_LEN_MAX_EN
  // Longest closed episode since reset, refreshed on every close.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_len_max <= '0;
    end else if (close_ep && (run_len > ovr_len_max)) begin
      ovr_len_max <= run_len;
    end
  end
`endif

endmodule

// File: tb/tb_ff_override_monitor.sv
// tb_ff_override_monitor
// ---------------------------------------------------------------------------
// Bench for ff_override_monitor with CNT_W = 8 and REL_CYC = 2. The bench
// emulates the monitored flop and the override harness itself, predicts the
// monitor's behaviour from the episode rules and compares through a
// scoreboard: predicted pulses and per-cycle status go into queues, and a
// monitor process pops and compares them as the DUT presents each cycle.
// ---------------------------------------------------------------------------
module tb_ff_override_monitor;

  localparam int CNT_W = 8;
  localparam int REL   = 2;
  localparam int SAT   = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             d   = 1'b0;
  logic             q   = 1'b0;
  logic             en  = 1'b1;
  logic             ovr_active;
  logic             ovr_start;
  logic             ovr_end;
  logic             ovr_val;
  logic [CNT_W-1:0] ovr_count;
  logic [CNT_W-1:0] ovr_len;
`ifdef OVR_LEN_MAX_EN
  logic [CNT_W-1:0] ovr_len_max;
`endif

  int unsigned cyc    = 0;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    int unsigned cycle;
    bit          is_end;
  } ev_t;

  typedef struct {
    int unsigned cycle;
    bit          active;
    bit          val;
    int          count;
    int          len;
    int          len_max;
  } st_t;

  ev_t evq[$];
  st_t stq[$];

  // Reference state: the harness's flop and the episode bookkeeping.
  bit flop_state = 1'b0;
  bit m_qexp     = 1'b0;
  bit m_in_ep    = 1'b0;
  bit m_val      = 1'b0;
  int m_mism     = 0;
  int m_streak   = 0;
  int m_count    = 0;
  int m_len      = 0;
  int m_len_max  = 0;

  ff_override_monitor #(
    .CNT_W  (CNT_W),
    .REL_CYC(REL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .d          (d),
    .q          (q),
    .en         (en),
    .ovr_active (ovr_active),
    .ovr_start  (ovr_start),
    .ovr_end    (ovr_end),
    .ovr_val    (ovr_val),
    .ovr_count  (ovr_count),
`ifdef OVR_LEN_MAX_EN
    .ovr_len_max(ovr_len_max),
`endif
    .ovr_len    (ovr_len)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Edge counter; edge N is the N-th rising edge of the run.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drives one edge worth of inputs. q is whatever the harness presents: the
  // forced value while an override is applied, otherwise the flop's content,
  // which keeps a released forced value until the next clock updates it.
  // The episode rules are evaluated here for the upcoming edge and the
  // predictions are queued for the monitor.
  task automatic applyStimulus(input bit r, input bit dd, input bit ee,
                               input bit fon, input bit fval);
    bit  qq;
    bit  mis;
    st_t s;
    ev_t e;
    qq  = fon ? fval : flop_state;
    rst = r;
    d   = dd;
    en  = ee;
    q   = qq;
    if (r) begin
      m_in_ep   = 1'b0;
      m_val     = 1'b0;
      m_mism    = 0;
      m_streak  = 0;
      m_count   = 0;
      m_len     = 0;
      m_len_max = 0;
    end else begin
      mis = ee && (qq != m_qexp);
      if (!m_in_ep) begin
        if (mis) begin
          m_in_ep  = 1'b1;
          m_mism   = 1;
          m_streak = 0;
          m_val    = qq;
          e.cycle  = cyc + 1;
          e.is_end = 1'b0;
          evq.push_back(e);
        end
      end else if (mis) begin
        m_mism   = (m_mism < SAT) ? m_mism + 1 : SAT;
        m_streak = 0;
      end else begin
        m_streak++;
        if (m_streak >= REL) begin
          m_in_ep   = 1'b0;
          m_len     = m_mism;
          m_count   = (m_count < SAT) ? m_count + 1 : SAT;
          m_len_max = (m_mism > m_len_max) ? m_mism : m_len_max;
          e.cycle   = cyc + 1;
          e.is_end  = 1'b1;
          evq.push_back(e);
        end
      end
    end
    m_qexp     = r ? 1'b0 : dd;
    flop_state = fon ? fval : (r ? 1'b0 : dd);
    s.cycle    = cyc + 1;
    s.active   = m_in_ep;
    s.val      = m_val;
    s.count    = m_count;
    s.len      = m_len;
    s.len_max  = m_len_max;
    stq.push_back(s);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: on each falling edge, pops the predicted status and
  // any predicted pulse for the edge just taken and compares against the DUT.
  // A cycle with no predicted pulse must show neither pulse.
  always @(negedge clk) begin
    st_t s;
    ev_t e;
    if (cyc > 0) begin
      if (stq.size() > 0 && stq[0].cycle == cyc) begin
        s = stq.pop_front();
        checkOutput("active", 32'(ovr_active), 32'(s.active));
        checkOutput("val", 32'(ovr_val), 32'(s.val));
        checkOutput("count", 32'(ovr_count), s.count);
        checkOutput("len", 32'(ovr_len), s.len);
`ifdef OVR_LEN_MAX_EN
        checkOutput("len_max", 32'(ovr_len_max), s.len_max);
`endif
      end
      if (evq.size() > 0 && evq[0].cycle == cyc) begin
        e = evq.pop_front();
        checkOutput("start_pulse", 32'(ovr_start), 32'(!e.is_end));
        checkOutput("end_pulse", 32'(ovr_end), 32'(e.is_end));
      end else begin
        checkOutput("start_idle", 32'(ovr_start), 0);
        checkOutput("end_idle", 32'(ovr_end), 0);
      end
    end
  end

  // Directed scenarios followed by a randomized soak.
  initial begin
    bit fon;
    bit fval;
    fon  = 1'b0;
    fval = 1'b0;

    $display("[TB] reset and clean random traffic");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    checkOutput("clean_active", 32'(ovr_active), 0);
    checkOutput("clean_count", 32'(ovr_count), 0);

    $display("[TB] forced 1 for 3 edges, stale for 1");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("stale_len", 32'(ovr_len), 4);
    checkOutput("stale_count", 32'(ovr_count), 1);
    checkOutput("stale_val", 32'(ovr_val), 1);

    $display("[TB] episode re-entered from recovery");
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("reenter_len", 32'(ovr_len), 3);
    checkOutput("reenter_count", 32'(ovr_count), 2);

    $display("[TB] long override saturates the length");
    repeat (300) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("sat_len", 32'(ovr_len), 255);
    checkOutput("sat_count", 32'(ovr_count), 3);
`ifdef OVR_LEN_MAX_EN
    checkOutput("sat_len_max", 32'(ovr_len_max), 255);
`endif

    $display("[TB] reset during an open episode");
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rst_active", 32'(ovr_active), 0);
    checkOutput("rst_count", 32'(ovr_count), 0);
    checkOutput("rst_len", 32'(ovr_len), 0);
    checkOutput("rst_val", 32'(ovr_val), 0);

    $display("[TB] enable dropped during an episode");
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("en_count", 32'(ovr_count), 1);
    checkOutput("en_active", 32'(ovr_active), 0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("en_ignored_count", 32'(ovr_count), 1);
    checkOutput("en_ignored_active", 32'(ovr_active), 0);

    $display("[TB] randomized soak");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        fon  = !fon;
        fval = 1'($urandom_range(0, 1));
      end
      applyStimulus(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) != 0), fon, fval);
    end
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("pending_pulses", 32'(evq.size()), 0);
    checkOutput("pending_status", 32'(stq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
